ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the single-cycle MIPS core. Holds the program counter, computes the next PC from the controller's select and the decoded branch/jump fields, and drives the word address into the instruction memory directly downstream. Also provides the PC+4 link value for `jal` and a fetch-address error flag.

## Interface

Parameters:
- `PC_RESET`, `32'h0000_3000`: PC value loaded on reset; base of instruction space.
- `IMEM_AW`, `11`: instruction-memory word-address width; the fetch window is 2^IMEM_AW words.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and instruction count this cycle.
- `npc_sel`  in  2  next-PC source: 00 sequential, 01 branch, 10 jump-immediate, 11 jump-register.
- `branch_taken`  in  1  branch condition result; used only when `npc_sel`=01.
- `imm16`  in  16  branch offset in words, signed.
- `target26`  in  26  `j`/`jal` word target.
- `jr_addr`  in  32  `jr`/`jalr` target byte address.
- `pc`  out  32  current PC register.
- `pc_plus4`  out  32  `pc + 4`, the link value.
- `imem_addr`  out  IMEM_AW  word address to instruction memory.
- `addr_err`  out  1  current PC misaligned or outside the fetch window.
- `instr_cnt`  out  32  count of completed fetch cycles since reset.

## Operation

- `pc_plus4 = pc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Next PC, when not stalled:
  - 00: `pc_plus4`.
  - 01: `pc_plus4 + (sign_extend(imm16) << 2)` if `branch_taken`, else `pc_plus4`. Modulo 2^32.
  - 10: `{pc_plus4[31:28], target26, 2'b00}`.
  - 11: `jr_addr`, loaded unmodified, including any misaligned low bits.
- `imem_addr = (pc - PC_RESET)[IMEM_AW+1:2]`. At `pc`=32'h3000 it is 0; at 32'h3004 it is 1.
- `addr_err` is 1 when any of these holds:
  - `pc[1:0] != 0`;
  - `pc < PC_RESET`;
  - `pc >= PC_RESET + 4*2^IMEM_AW`.
- The block never self-corrects on `addr_err`. Trap handling belongs to the controller.
- `instr_cnt` increments by 1 on every rising edge with `reset`=0 and `stall`=0. It wraps modulo 2^32.
- Priority: `reset` > `stall` > `npc_sel`.

## Timing

- Reset values: `pc`=`PC_RESET`, `pc_plus4`=`PC_RESET+4`, `imem_addr`=0, `addr_err`=0, `instr_cnt`=0.
- Reset takes effect at the first rising edge where `reset`=1. Asserting it mid-program discards the pending next PC.
- `pc` and `instr_cnt` are registers and change only on the rising edge.
- `pc_plus4`, `imem_addr` and `addr_err` are combinational from `pc`. They are valid in the same cycle as `pc`, so instruction memory returns the instruction for the current PC within that cycle.
- Next-PC inputs are sampled at the rising edge and take effect in the following cycle. Fetch-to-redirect latency is one cycle, with no delay slot.
- `stall`=1 holds `pc` and `instr_cnt`. All next-PC inputs are ignored in that cycle.
- Illegal combinations need no special handling: the encoding is exhaustive. `branch_taken` is ignored unless `npc_sel`=01.

## Structure

- Shared package `mips_pkg` holds:
  - `npc_sel` encodings: `NPC_SEQ`, `NPC_BR`, `NPC_J`, `NPC_JR`;
  - `PC_RESET_DEFAULT`;
  - `IMEM_AW_DEFAULT`.
- One sub-module, `npc`: purely combinational next-PC calculator. Inputs are `pc`, `npc_sel`, `branch_taken`, `imm16`, `target26` and `jr_addr`; outputs are `npc` and `pc_plus4`.
- The top level holds:
  - the PC and counter registers;
  - the stall/reset muxing;
  - the address translation and `addr_err` compare.

## Test plan

- **Reset release:** `reset`=1 for 2 cycles, then 0 with `npc_sel`=00 for 3 cycles. Expect `pc` = 3000, then 3004, 3008, 300C. `imem_addr` = 0, 1, 2, 3. `instr_cnt` = 0, 1, 2, 3.
- **Branch:** at `pc`=3010, `npc_sel`=01.
  - `branch_taken`=1, `imm16`=16'hFFFC: next `pc`=3004.
  - `branch_taken`=0: next `pc`=3014.
- **Jump immediate and register:**
  - At `pc`=3000, `npc_sel`=10, `target26`=26'h0000C10: next `pc`=3040. `pc_plus4` in the jump cycle = 3004.
  - Then `npc_sel`=11, `jr_addr`=3100: next `pc`=3100.
- **Stall:** `stall`=1 for 3 cycles at `pc`=3008 with `npc_sel`=10. Expect `pc` and `instr_cnt` unchanged. The jump is applied only in the first cycle after `stall` drops.
- **Address error:**
  - `jr_addr`=3002: `addr_err`=1 the next cycle.
  - `jr_addr`=5000: `addr_err`=1.
  - `jr_addr`=4FFC: `addr_err`=0, `imem_addr`=11'h7FF.
- **Reset mid-operation:** `reset`=1 together with `npc_sel`=11 and `stall`=1. Next `pc`=3000 and `instr_cnt`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: next-PC select encodings
// and default fetch-space geometry.
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int unsigned IMEM_AW_DEFAULT  = 11;

endpackage

// File: rtl/npc.sv
// Combinational next-PC calculator: sequential, PC-relative branch,
// pseudo-direct jump and register jump.
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] jr_addr,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4
);

  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;

  assign pc_plus4 = pc + 32'd4;
  // Branch offset counts words relative to the delay-slot-free PC+4.
  assign w_br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign w_br_tgt = pc_plus4 + w_br_off;
  assign w_j_tgt  = {pc_plus4[31:28], target26, 2'b00};

  always_comb begin
    npc = pc_plus4;
    unique case (npc_sel_e'(npc_sel))
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = branch_taken ? w_br_tgt : pc_plus4;
      NPC_J:   npc = w_j_tgt;
      NPC_JR:  npc = jr_addr;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC and fetch-count registers, next-PC selection,
// word-address translation into instruction memory and fetch-address check.
module ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         npc_sel,
  input  logic               branch_taken,
  input  logic [15:0]        imm16,
  input  logic [25:0]        target26,
  input  logic [31:0]        jr_addr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               addr_err,
  output logic [31:0]        instr_cnt
);

  // One past the last byte of the fetch window; 33 bits so it cannot wrap.
  localparam logic [32:0] PcLimit = {1'b0, PC_RESET} + (33'd4 << IMEM_AW);

  logic [31:0] r_pc;
  logic [31:0] r_cnt;
  logic [31:0] w_pc_d;
  logic [31:0] w_cnt_d;
  logic [31:0] w_npc;
  logic [31:0] w_off;
  logic        unused_off;

  npc u_npc (
    .pc           (r_pc),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .jr_addr      (jr_addr),
    .npc          (w_npc),
    .pc_plus4     (pc_plus4)
  );

  always_comb begin
    w_pc_d  = w_npc;
    w_cnt_d = r_cnt + 32'd1;
    if (reset) begin
      w_pc_d  = PC_RESET;
      w_cnt_d = 32'd0;
    end else if (stall) begin
      w_pc_d  = r_pc;
      w_cnt_d = r_cnt;
    end
  end

  always_ff @(posedge clk) begin
    r_pc  <= w_pc_d;
    r_cnt <= w_cnt_d;
  end

  assign w_off      = r_pc - PC_RESET;
  assign imem_addr  = w_off[IMEM_AW+1:2];
  assign unused_off = ^{w_off[31:IMEM_AW+2], w_off[1:0]};

  // Only flags the fault; recovery is the controller's job.
  assign addr_err = (r_pc[1:0] != 2'b00) || (r_pc < PC_RESET) || ({1'b0, r_pc} >= PcLimit);

  assign pc        = r_pc;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: directed vectors push expected PC/count, a
// negedge monitor pops and checks every visible output.
module tb_ifu;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [10:0] imem_addr;
  logic        addr_err;
  logic [31:0] instr_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ifu u_dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .jr_addr      (jr_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem_addr    (imem_addr),
    .addr_err     (addr_err),
    .instr_cnt    (instr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare all outputs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [31:0] off;
      logic        err;
      e   = q.pop_front();
      off = e.pc - 32'h0000_3000;
      err = (e.pc[1:0] != 2'b00) || (e.pc < 32'h0000_3000) || (e.pc >= 32'h0000_5000);
      chk("pc", pc, e.pc);
      chk("instr_cnt", instr_cnt, e.cnt);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("imem_addr", {21'd0, imem_addr}, {21'd0, off[12:2]});
      chk("addr_err", {31'd0, addr_err}, {31'd0, err});
    end
  end

  task automatic cyc(input logic rst, input logic stl, input logic [1:0] sel,
                     input logic bt, input logic [15:0] imm, input logic [25:0] tgt,
                     input logic [31:0] jr, input logic [31:0] exp_pc,
                     input logic [31:0] exp_cnt);
    reset        = rst;
    stall        = stl;
    npc_sel      = sel;
    branch_taken = bt;
    imm16        = imm;
    target26     = tgt;
    jr_addr      = jr;
    @(posedge clk);
    #1;
    q.push_back('{pc: exp_pc, cnt: exp_cnt});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_sel = 2'b00; branch_taken = 1'b0;
    imm16 = '0; target26 = '0; jr_addr = '0;

    // Reset release then sequential fetch
    cyc(1, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3000, 0);
    cyc(1, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3000, 0);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3004, 1);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3008, 2);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h300C, 3);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3010, 4);
    // Branch taken backwards from 3010
    cyc(0, 0, 2'b01, 1, 16'hFFFC, 26'h0, 32'h0, 32'h3004, 5);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3008, 6);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h300C, 7);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3010, 8);
    // Branch not taken; then branch_taken ignored under sequential select
    cyc(0, 0, 2'b01, 0, 16'hFFFC, 26'h0, 32'h0, 32'h3014, 9);
    cyc(0, 0, 2'b00, 1, 16'hFFFC, 26'h0, 32'h0, 32'h3018, 10);
    // Jumps from 3000
    cyc(1, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3000, 0);
    cyc(0, 0, 2'b10, 0, 16'h0000, 26'h0000C10, 32'h0, 32'h3040, 1);
    cyc(0, 0, 2'b11, 0, 16'h0000, 26'h0, 32'h3100, 32'h3100, 2);
    // Stall with a pending jump at 3008
    cyc(0, 0, 2'b11, 0, 16'h0000, 26'h0, 32'h3008, 32'h3008, 3);
    cyc(0, 1, 2'b10, 0, 16'h0000, 26'h0000C20, 32'h0, 32'h3008, 3);
    cyc(0, 1, 2'b10, 0, 16'h0000, 26'h0000C20, 32'h0, 32'h3008, 3);
    cyc(0, 1, 2'b10, 0, 16'h0000, 26'h0000C20, 32'h0, 32'h3008, 3);
    cyc(0, 0, 2'b10, 0, 16'h0000, 26'h0000C20, 32'h0, 32'h3080, 4);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0000C20, 32'h0, 32'h3084, 5);
    // Address errors: misaligned, above, last legal word, below, wrap of pc_plus4
    cyc(0, 0, 2'b11, 0, 16'h0000, 26'h0, 32'h3002, 32'h3002, 6);
    cyc(0, 0, 2'b11, 0, 16'h0000, 26'h0, 32'h5000, 32'h5000, 7);
    cyc(0, 0, 2'b11, 0, 16'h0000, 26'h0, 32'h4FFC, 32'h4FFC, 8);
    cyc(0, 0, 2'b11, 0, 16'h0000, 26'h0, 32'h2FFC, 32'h2FFC, 9);
    cyc(0, 0, 2'b11, 0, 16'h0000, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 10);
    // Reset beats stall and jump-register
    cyc(1, 1, 2'b11, 0, 16'h0000, 26'h0, 32'h5000, 32'h3000, 0);
    cyc(0, 0, 2'b00, 0, 16'h0000, 26'h0, 32'h0, 32'h3004, 1);

    // Spot-check values the plan names explicitly, independent of the model
    @(negedge clk);
    #1;
    chk("last_pc", pc, 32'h3004);
    chk("last_imem", {21'd0, imem_addr}, 32'd1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
